// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: lets N byte-stream clients share one uart_tx, one whole message at a time,
// in round-robin order. A watchdog takes the grant away from an owner that stops sending.
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1000000,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   wr,
  input  logic [8*N-1:0] din,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ready,
  output logic           timeout,
  output logic           uart_wr,
  output logic [7:0]     uart_din,
  input  logic           uart_ready
);
  localparam int            IW        = (N > 1) ? $clog2(N) : 1;
  localparam int            CW        = (TW > 0) ? TW : 1;
  localparam logic [CW-1:0] WDOG_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] WDOG_ONE  = CW'(1);
  localparam logic [IW-1:0] LAST_RST  = IW'(N - 1);
  localparam logic [N-1:0]  ONE_HOT0  = N'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e        state_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  block_q;
  logic [N-1:0]  block_d;
  logic [N-1:0]  eligible_d;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] pick_d;
  logic [CW-1:0] wdog_q;
  logic          timeout_q;
  logic          own_req_d;
  logic          own_wr_d;
  logic          revoke_d;

  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] elig, input logic [IW-1:0] last);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && elig[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // A revoked client stays blocked until it lowers req for at least one cycle.
  always_comb begin
    eligible_d = req & ~block_q;
    pick_d     = rr_pick(eligible_d, last_q);
    own_req_d  = |(req & grant_q);
    own_wr_d   = |(wr & grant_q);
    revoke_d   = (TIMEOUT != 0) && (state_q == OWN) && own_req_d && uart_ready &&
                 !own_wr_d && (wdog_q == WDOG_LAST);
    block_d    = (block_q & req) | (revoke_d ? grant_q : '0);
  end

  always_comb begin
    uart_din = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        uart_din = uart_din | din[8*i +: 8];
      end
    end
  end

  assign grant   = grant_q;
  assign ready   = grant_q & {N{uart_ready}};
  assign uart_wr = own_wr_d & uart_ready;
  assign timeout = timeout_q;

  // Release is checked before the watchdog so a simultaneous drop of req wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= LAST_RST;
      wdog_q    <= '0;
      block_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      block_q   <= block_d;
      case (state_q)
        IDLE: begin
          if (|eligible_d) begin
            state_q <= OWN;
            grant_q <= ONE_HOT0 << pick_d;
            owner_q <= pick_d;
            wdog_q  <= '0;
          end
        end
        OWN: begin
          if (!own_req_d) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
          end else if (revoke_d) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= owner_q;
            timeout_q <= 1'b1;
          end else if (uart_ready) begin
            wdog_q <= own_wr_d ? '0 : wdog_q + WDOG_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by random client traffic,
// checked against a transaction-level ownership model and a byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int N       = 2;
  localparam int TIMEOUT = 100;
  localparam logic [N-1:0] ONE_N = N'(1);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   wr;
  logic [8*N-1:0] din;
  logic [N-1:0]   grant;
  logic [N-1:0]   ready;
  logic           timeout;
  logic           uart_wr;
  logic [7:0]     uart_din;
  logic           uart_ready;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .din(din),
    .grant(grant), .ready(ready), .timeout(timeout),
    .uart_wr(uart_wr), .uart_din(uart_din), .uart_ready(uart_ready)
  );

  int checks = 0;
  int passed = 0;

  // reference model: owner index (-1 = nobody), last owner, idle count, blocked clients
  int         m_owner;
  int         m_last;
  int         m_idle;
  bit [N-1:0] m_block;
  bit         m_to;

  logic [N-1:0] e_grant, e_ready;
  logic         e_to, e_wr;
  logic [7:0]   e_din;
  int           e_acc;
  logic [7:0]   sb_q[$];
  bit           mon_en = 1'b0;

  int busy;
  int msg_left[N];
  bit stall[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [7:0] b;
      check("grant", 32'(grant), 32'(e_grant));
      check("ready", 32'(ready), 32'(e_ready));
      check("timeout", 32'(timeout), 32'(e_to));
      check("uart_din", 32'(uart_din), 32'(e_din));
      if (uart_wr) begin
        if (sb_q.size() == 0) check("uart_wr_spurious", 32'(uart_wr), 32'(1'b0));
        else begin
          b = sb_q.pop_front();
          check("sent_byte", 32'(uart_din), 32'(b));
        end
      end else if (sb_q.size() != 0) begin
        check("uart_wr_missing", 32'(uart_wr), 32'(1'b1));
        b = sb_q.pop_front();
      end
    end
  end

  task automatic model_step();
    bit [N-1:0] nb;
    int c;
    if (!reset) begin
      m_owner = -1; m_last = N - 1; m_idle = 0; m_block = '0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      nb   = m_block & req;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (m_owner < 0 && req[c] && !m_block[c]) begin
            m_owner = c;
            m_idle  = 0;
          end
        end
      end else if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (uart_ready) begin
        if (wr[m_owner]) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            nb[m_owner] = 1'b1;
            m_last      = m_owner;
            m_owner     = -1;
            m_to        = 1'b1;
          end
        end
      end
      m_block = nb;
    end
  endtask

  task automatic gen_clients();
    for (int i = 0; i < N; i++) begin
      din[8*i +: 8] = 8'($urandom);
      if (!req[i]) begin
        wr[i] = ($urandom_range(3, 0) == 0);
        if ($urandom_range(7, 0) == 0) begin
          req[i]      = 1'b1;
          stall[i]    = ($urandom_range(4, 0) == 0);
          msg_left[i] = $urandom_range(6, 1);
        end
      end else if (m_owner == i) begin
        if (msg_left[i] <= 0) begin
          req[i] = 1'b0; wr[i] = 1'b0;
        end else if (stall[i]) begin
          wr[i] = 1'b0;
          if ($urandom_range(149, 0) == 0) req[i] = 1'b0;
        end else begin
          wr[i] = uart_ready ? ($urandom_range(3, 0) != 0) : ($urandom_range(7, 0) == 0);
        end
      end else begin
        wr[i] = ($urandom_range(3, 0) == 0);
        if (stall[i] ? ($urandom_range(15, 0) == 0) : ($urandom_range(63, 0) == 0)) req[i] = 1'b0;
      end
    end
  endtask

  task automatic tick(input bit rnd, input logic rst_v, input logic [N-1:0] r, input logic [N-1:0] w,
                      input logic [8*N-1:0] d, input bit gate, input bit hold_busy);
    @(posedge clk);
    model_step();
    if (e_wr) begin
      busy = $urandom_range(6, 2);
      if (msg_left[e_acc] > 0) msg_left[e_acc]--;
    end else if (busy > 0) busy--;
    #1;
    reset      = rst_v;
    uart_ready = (busy == 0) && !hold_busy;
    if (rnd) gen_clients();
    else begin
      req = r;
      wr  = gate ? (w & {N{uart_ready}}) : w;
      din = d;
    end
    e_grant = (m_owner >= 0) ? (ONE_N << m_owner) : '0;
    e_ready = uart_ready ? e_grant : '0;
    e_to    = m_to;
    e_wr    = (m_owner >= 0) && wr[m_owner] && uart_ready;
    e_din   = (m_owner >= 0) ? din[8*m_owner +: 8] : 8'h00;
    if (e_wr) begin
      sb_q.push_back(e_din);
      e_acc = m_owner;
    end
  endtask

  task automatic send(input int c, input logic [N-1:0] r, input logic [7:0] b);
    logic [8*N-1:0] d;
    d = '0;
    d[8*c +: 8] = b;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b1, r, ONE_N << c, d, 1'b1, 1'b0);
      if (e_wr) break;
    end
  endtask

  initial begin
    logic [N-1:0] r;
    reset = 1'b0; req = '0; wr = '0; din = '0; uart_ready = 1'b1; busy = 0;
    m_owner = -1; m_last = N - 1; m_idle = 0; m_block = '0; m_to = 1'b0;
    e_grant = '0; e_ready = '0; e_to = 1'b0; e_wr = 1'b0; e_din = 8'h00; e_acc = 0;
    for (int i = 0; i < N; i++) begin msg_left[i] = 0; stall[i] = 1'b0; end

    repeat (10) begin
      tick(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
      mon_en = 1'b1;
    end
    repeat (4) tick(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

    // single client, one byte
    repeat (2) tick(1'b0, 1'b1, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0);
    send(0, 2'b01, 8'h41);
    repeat (3) tick(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

    // both request straight after reset: client 0 first, then client 1 after a gap
    tick(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000, 1'b0, 1'b0);
    send(0, 2'b11, 8'h58);
    send(0, 2'b11, 8'h0D);
    send(0, 2'b11, 8'h0A);
    repeat (2) tick(1'b0, 1'b1, 2'b10, 2'b00, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000, 1'b0, 1'b0);
    send(1, 2'b11, 8'hC1);
    send(1, 2'b11, 8'hC2);

    // non-owner write and write while uart busy are both ignored
    tick(1'b0, 1'b1, 2'b01, 2'b00, 16'h0033, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 2'b11, 2'b00, 16'h5533, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 2'b11, 2'b10, 16'h5533, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 2'b11, 2'b01, 16'h5533, 1'b0, 1'b1);

    // round robin: owner lets go for one cycle while the other keeps requesting
    for (int n = 0; n < 4; n++) begin
      r = 2'b11;
      if (m_owner >= 0) r = r & ~(ONE_N << m_owner);
      tick(1'b0, 1'b1, r, 2'b00, 16'h0000, 1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000, 1'b0, 1'b0);
    end

    // watchdog: stalled client 0 is revoked, stays out while req held, re-granted after a drop
    tick(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0);
    repeat (115) tick(1'b0, 1'b1, 2'b11, 2'b00, 16'h0000, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1, 2'b01, 2'b00, 16'h0000, 1'b0, 1'b0);
    send(0, 2'b01, 8'h7E);
    repeat (2) tick(1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

    repeat (5000) tick(1'b1, 1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
